// File: rtl/lpc_io_dispatch_pkg.sv
// Shared definitions for the LPC I/O dispatcher: FSM state encodings, the
// value returned for unclaimed or timed-out reads, and the default window table.
package lpc_io_dispatch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WR_ACC,
        ST_WR_DONE,
        ST_WR_RELEASE,
        ST_RD_ACC,
        ST_RD_VALID,
        ST_RD_RELEASE
    } lpc_io_state_t;

    localparam logic [7:0] LPC_IO_MISS_DATA = 8'hFF;

    // Client i occupies bits [16i+15:16i] of the flat tables.
    localparam int          LPC_IO_DEF_CLIENTS = 4;
    localparam logic [63:0] LPC_IO_DEF_BASE    = {16'h0080, 16'h0060, 16'h0064, 16'h002E};
    localparam logic [63:0] LPC_IO_DEF_MASK    = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE};

    // Index width that stays legal for a single-client build.
    function automatic int lpc_io_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lpc_io_window_decode.sv
// Combinational address-window decoder: reports whether any client window
// claims the address and, if several do, the lowest-numbered one.
module lpc_io_window_decode
    import lpc_io_dispatch_pkg::*;
#(
    parameter int                        NUM_CLIENTS = LPC_IO_DEF_CLIENTS,
    parameter logic [16*NUM_CLIENTS-1:0] BASE        = LPC_IO_DEF_BASE,
    parameter logic [16*NUM_CLIENTS-1:0] MASK        = LPC_IO_DEF_MASK,
    localparam int                       IDX_W       = lpc_io_idx_w(NUM_CLIENTS)
) (
    input  logic [15:0]      addr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    // Scanning downward lets the lowest matching index overwrite the others.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (((addr ^ BASE[16*i +: 16]) & MASK[16*i +: 16]) == 16'h0000) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/lpc_io_dispatch.sv
// LPC I/O transaction controller: decodes the peripheral's I/O cycles onto
// client register blocks and bounds every client access with a timeout.
module lpc_io_dispatch
    import lpc_io_dispatch_pkg::*;
#(
    parameter int                        NUM_CLIENTS = LPC_IO_DEF_CLIENTS,
    parameter logic [16*NUM_CLIENTS-1:0] BASE        = LPC_IO_DEF_BASE,
    parameter logic [16*NUM_CLIENTS-1:0] MASK        = LPC_IO_DEF_MASK,
    parameter int                        TIMEOUT     = 255
) (
    input  logic                       clk_i,
    input  logic                       nrst_i,
    input  logic [15:0]                lpc_addr_i,
    input  logic [7:0]                 lpc_data_i,
    input  logic                       lpc_data_wr_i,
    output logic                       lpc_wr_done_o,
    input  logic                       lpc_rd_req_i,
    output logic [7:0]                 lpc_data_o,
    output logic                       lpc_data_oe_o,
    output logic                       lpc_data_rd_o,
    input  logic                       lpc_rd_done_i,
    output logic [15:0]                cl_addr_o,
    output logic [7:0]                 cl_wdata_o,
    output logic [NUM_CLIENTS-1:0]     cl_wr_o,
    output logic [NUM_CLIENTS-1:0]     cl_rd_o,
    input  logic [NUM_CLIENTS-1:0]     cl_ack_i,
    input  logic [8*NUM_CLIENTS-1:0]   cl_rdata_i,
    output logic                       timeout_o
);

    localparam int IDX_W = lpc_io_idx_w(NUM_CLIENTS);

    lpc_io_state_t            state;
    lpc_io_state_t            state_next;
    logic                     is_wr;
    logic [15:0]              tmo_cnt;
    logic                     expire;
    logic                     tmo_evt;
    logic                     dec_hit;
    logic [IDX_W-1:0]         dec_idx;
    logic [NUM_CLIENTS-1:0]   sel_vec;
    logic                     ack_sel;
    logic [7:0]               rdata_sel;

    // The latched address is frozen until IDLE, so the decode result is
    // stable for the whole transaction and doubles as the client select.
    lpc_io_window_decode #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .BASE        (BASE),
        .MASK        (MASK)
    ) u_decode (
        .addr (cl_addr_o),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    always_comb begin
        sel_vec   = '0;
        ack_sel   = 1'b0;
        rdata_sel = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (dec_idx == IDX_W'(i)) begin
                sel_vec[i] = 1'b1;
                ack_sel    = cl_ack_i[i];
                rdata_sel  = cl_rdata_i[8*i +: 8];
            end
        end
    end

    assign expire = (tmo_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tmo_evt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (lpc_data_wr_i || lpc_rd_req_i) begin
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_hit) begin
                    state_next = is_wr ? ST_WR_ACC : ST_RD_ACC;
                end else begin
                    state_next = is_wr ? ST_WR_DONE : ST_RD_VALID;
                end
            end
            ST_WR_ACC: begin
                if (ack_sel) begin
                    state_next = ST_WR_DONE;
                end else if (expire) begin
                    state_next = ST_WR_DONE;
                    tmo_evt    = 1'b1;
                end
            end
            ST_WR_DONE: begin
                state_next = ST_WR_RELEASE;
            end
            ST_WR_RELEASE: begin
                if (!lpc_data_wr_i) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RD_ACC: begin
                if (ack_sel) begin
                    state_next = ST_RD_VALID;
                end else if (expire) begin
                    state_next = ST_RD_VALID;
                    tmo_evt    = 1'b1;
                end
            end
            ST_RD_VALID: begin
                if (lpc_rd_done_i) begin
                    state_next = ST_RD_RELEASE;
                end
            end
            ST_RD_RELEASE: begin
                if (!lpc_rd_req_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            is_wr         <= 1'b0;
            tmo_cnt       <= '0;
            cl_addr_o     <= '0;
            cl_wdata_o    <= '0;
            cl_wr_o       <= '0;
            cl_rd_o       <= '0;
            lpc_wr_done_o <= 1'b0;
            lpc_data_rd_o <= 1'b0;
            lpc_data_oe_o <= 1'b0;
            lpc_data_o    <= '0;
            timeout_o     <= 1'b0;
        end else begin
            if (state == ST_IDLE && state_next == ST_DECODE) begin
                cl_addr_o  <= lpc_addr_i;
                cl_wdata_o <= lpc_data_i;
                is_wr      <= lpc_data_wr_i;
            end

            if (state == ST_WR_ACC || state == ST_RD_ACC) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end else begin
                tmo_cnt <= '0;
            end

            cl_wr_o       <= (state_next == ST_WR_ACC) ? sel_vec : '0;
            cl_rd_o       <= (state_next == ST_RD_ACC) ? sel_vec : '0;
            lpc_wr_done_o <= (state_next == ST_WR_DONE);
            lpc_data_rd_o <= (state_next == ST_RD_VALID);
            lpc_data_oe_o <= (state_next == ST_RD_VALID);
            timeout_o     <= tmo_evt;

            if (state == ST_DECODE && !dec_hit && !is_wr) begin
                lpc_data_o <= LPC_IO_MISS_DATA;
            end else if (state == ST_RD_ACC) begin
                if (ack_sel) begin
                    lpc_data_o <= rdata_sel;
                end else if (expire) begin
                    lpc_data_o <= LPC_IO_MISS_DATA;
                end
            end
        end
    end

endmodule

// File: tb/tb_lpc_io_dispatch.sv
// Scoreboard bench for lpc_io_dispatch: directed transactions push expected
// events, and a negedge monitor pops and compares whatever the DUT presents.
module tb_lpc_io_dispatch;

    localparam int          NC   = 4;
    // Client 0 = 0x80, 1 = 0x60, 2 = 0x64, 3 = 0x20/FFB0 (claims 0x2F, 0x60, 0x64).
    localparam logic [63:0] BASE = {16'h0020, 16'h0064, 16'h0060, 16'h0080};
    localparam logic [63:0] MASK = {16'hFFB0, 16'hFFFF, 16'hFFFF, 16'hFFFF};

    localparam int EV_WSTB   = 1;
    localparam int EV_RSTB   = 2;
    localparam int EV_STBEND = 3;
    localparam int EV_TMO    = 4;
    localparam int EV_WDONE  = 5;
    localparam int EV_RDATA  = 6;

    logic          clk = 1'b0;
    logic          nrst_i;
    logic [15:0]   lpc_addr_i;
    logic [7:0]    lpc_data_i;
    logic          lpc_data_wr_i;
    logic          lpc_wr_done_o;
    logic          lpc_rd_req_i;
    logic [7:0]    lpc_data_o;
    logic          lpc_data_oe_o;
    logic          lpc_data_rd_o;
    logic          lpc_rd_done_i;
    logic [15:0]   cl_addr_o;
    logic [7:0]    cl_wdata_o;
    logic [NC-1:0] cl_wr_o;
    logic [NC-1:0] cl_rd_o;
    logic [NC-1:0] cl_ack_i;
    logic [8*NC-1:0] cl_rdata_i;
    logic          timeout_o;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    always #5 clk = ~clk;

    lpc_io_dispatch #(
        .NUM_CLIENTS (NC),
        .BASE        (BASE),
        .MASK        (MASK),
        .TIMEOUT     (255)
    ) dut (
        .clk_i         (clk),
        .nrst_i        (nrst_i),
        .lpc_addr_i    (lpc_addr_i),
        .lpc_data_i    (lpc_data_i),
        .lpc_data_wr_i (lpc_data_wr_i),
        .lpc_wr_done_o (lpc_wr_done_o),
        .lpc_rd_req_i  (lpc_rd_req_i),
        .lpc_data_o    (lpc_data_o),
        .lpc_data_oe_o (lpc_data_oe_o),
        .lpc_data_rd_o (lpc_data_rd_o),
        .lpc_rd_done_i (lpc_rd_done_i),
        .cl_addr_o     (cl_addr_o),
        .cl_wdata_o    (cl_wdata_o),
        .cl_wr_o       (cl_wr_o),
        .cl_rd_o       (cl_rd_o),
        .cl_ack_i      (cl_ack_i),
        .cl_rdata_i    (cl_rdata_i),
        .timeout_o     (timeout_o)
    );

    function automatic logic [31:0] pack_stb(input logic [3:0] s, input logic [7:0] d,
                                             input logic [15:0] a);
        return {4'h0, s, d, a};
    endfunction

    task automatic expect_ev(input int kind, input logic [31:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic got(input int kind, input logic [31:0] val);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event kind=%0d val=%h required=none", kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val) begin
                bad++;
                $display("FAIL event kind=%0d val=%h required kind=%0d val=%h",
                         kind, val, e.kind, e.val);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_stb(input string name, input int limit);
        int i;
        i = 0;
        while ((cl_wr_o | cl_rd_o) == '0 && i < limit) begin
            tick(1);
            i++;
        end
        chk(name, 32'((cl_wr_o | cl_rd_o) != '0), 32'd1);
    endtask

    task automatic wait_rdv(input string name, input int limit);
        int i;
        i = 0;
        while (!lpc_data_rd_o && i < limit) begin
            tick(1);
            i++;
        end
        chk(name, 32'(lpc_data_rd_o), 32'd1);
    endtask

    task automatic rd_finish();
        lpc_rd_done_i = 1'b1;
        tick(1);
        lpc_rd_done_i = 1'b0;
        tick(1);
        lpc_rd_req_i = 1'b0;
        tick(2);
    endtask

    task automatic wr_finish();
        tick(1);
        lpc_data_wr_i = 1'b0;
        tick(2);
    endtask

    // Monitor: converts DUT output activity into events for the scoreboard.
    initial begin : monitor
        logic [3:0] pw, pr;
        logic       pa, prv;
        int         sc;
        pw = '0; pr = '0; pa = 1'b0; prv = 1'b0; sc = 0;
        forever begin
            @(negedge clk);
            if (!nrst_i) begin
                pw = '0; pr = '0; pa = 1'b0; prv = 1'b0; sc = 0;
            end else begin
                total++;
                if ($countones(cl_wr_o | cl_rd_o) > 1) begin
                    bad++;
                    $display("FAIL strobe_onehot got wr=%b rd=%b required at most one bit", cl_wr_o, cl_rd_o);
                end
                if (cl_wr_o != '0 && pw == '0) got(EV_WSTB, pack_stb(cl_wr_o, cl_wdata_o, cl_addr_o));
                if (cl_rd_o != '0 && pr == '0) got(EV_RSTB, pack_stb(cl_rd_o, 8'h00, cl_addr_o));
                if ((cl_wr_o | cl_rd_o) != '0) begin
                    sc++;
                end else if (pa) begin
                    got(EV_STBEND, 32'(sc));
                    sc = 0;
                end
                if (timeout_o) got(EV_TMO, 32'd0);
                if (lpc_wr_done_o) got(EV_WDONE, 32'd0);
                if (lpc_data_rd_o && !prv) got(EV_RDATA, {23'd0, lpc_data_oe_o, lpc_data_o});
                pw  = cl_wr_o;
                pr  = cl_rd_o;
                pa  = ((cl_wr_o | cl_rd_o) != '0);
                prv = lpc_data_rd_o;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        nrst_i        = 1'b0;
        lpc_addr_i    = '0;
        lpc_data_i    = '0;
        lpc_data_wr_i = 1'b0;
        lpc_rd_req_i  = 1'b0;
        lpc_rd_done_i = 1'b0;
        cl_ack_i      = '0;
        cl_rdata_i    = '0;
        #1;
        chk("reset_strobes", {24'd0, cl_wr_o, cl_rd_o}, 32'd0);
        chk("reset_flags", {28'd0, lpc_wr_done_o, lpc_data_rd_o, lpc_data_oe_o, timeout_o}, 32'd0);
        chk("reset_regs", {lpc_data_o, cl_wdata_o, cl_addr_o}, 32'd0);
        tick(2);
        nrst_i = 1'b1;
        tick(2);

        // Write 0x80 <- 0x5A, client 0 acks on its third strobe cycle.
        expect_ev(EV_WSTB, pack_stb(4'b0001, 8'h5A, 16'h0080));
        expect_ev(EV_STBEND, 32'd3);
        expect_ev(EV_WDONE, 32'd0);
        lpc_addr_i = 16'h0080; lpc_data_i = 8'h5A; lpc_data_wr_i = 1'b1;
        wait_stb("wr80_strobe", 20);
        tick(2);
        cl_ack_i = 4'b0001;
        tick(1);
        cl_ack_i = '0;
        chk("wr80_done_level", 32'(lpc_wr_done_o), 32'd1);
        wr_finish();

        // Read 0x2F through client 3's masked window, data 0xC3.
        expect_ev(EV_RSTB, pack_stb(4'b1000, 8'h00, 16'h002F));
        expect_ev(EV_STBEND, 32'd1);
        expect_ev(EV_RDATA, 32'h1C3);
        lpc_addr_i = 16'h002F; lpc_rd_req_i = 1'b1;
        wait_stb("rd2f_strobe", 20);
        cl_rdata_i[31:24] = 8'hC3; cl_ack_i = 4'b1000;
        tick(1);
        cl_ack_i = '0; cl_rdata_i = '0;
        tick(3);
        chk("rd2f_hold", {23'd0, lpc_data_rd_o, lpc_data_o}, 32'h1C3);
        lpc_rd_done_i = 1'b1;
        tick(1);
        lpc_rd_done_i = 1'b0;
        chk("rd2f_release", {30'd0, lpc_data_rd_o, lpc_data_oe_o}, 32'd0);
        tick(2);
        lpc_rd_req_i = 1'b0;
        tick(2);

        // Write miss at 0x3F8: done pulse right after decode, no strobe.
        expect_ev(EV_WDONE, 32'd0);
        lpc_addr_i = 16'h03F8; lpc_data_i = 8'h12; lpc_data_wr_i = 1'b1;
        tick(1);
        chk("wmiss_decode", 32'(lpc_wr_done_o), 32'd0);
        tick(1);
        chk("wmiss_done", {27'd0, cl_wr_o, lpc_wr_done_o}, 32'd1);
        tick(1);
        chk("wmiss_pulse", 32'(lpc_wr_done_o), 32'd0);
        lpc_data_wr_i = 1'b0;
        tick(2);

        // Read miss at 0x3F8 returns 0xFF.
        expect_ev(EV_RDATA, 32'h1FF);
        lpc_rd_req_i = 1'b1;
        tick(2);
        chk("rmiss_valid", {23'd0, lpc_data_rd_o, lpc_data_o}, 32'h1FF);
        rd_finish();

        // Read 0x60, client 1 never acks: timeout after 255 strobe cycles.
        expect_ev(EV_RSTB, pack_stb(4'b0010, 8'h00, 16'h0060));
        expect_ev(EV_STBEND, 32'd255);
        expect_ev(EV_TMO, 32'd0);
        expect_ev(EV_RDATA, 32'h1FF);
        lpc_addr_i = 16'h0060; lpc_rd_req_i = 1'b1;
        wait_stb("rdtmo_strobe", 20);
        wait_rdv("rdtmo_valid", 400);
        rd_finish();

        // Read 0x64 (clients 2 and 3 overlap), ack lands on the expiry cycle.
        expect_ev(EV_RSTB, pack_stb(4'b0100, 8'h00, 16'h0064));
        expect_ev(EV_STBEND, 32'd255);
        expect_ev(EV_RDATA, 32'h13C);
        lpc_addr_i = 16'h0064; lpc_rd_req_i = 1'b1;
        wait_stb("rdlate_strobe", 20);
        tick(254);
        cl_rdata_i[23:16] = 8'h3C; cl_ack_i = 4'b0100;
        tick(1);
        cl_ack_i = '0; cl_rdata_i = '0;
        chk("rdlate_no_tmo", 32'(timeout_o), 32'd0);
        rd_finish();

        // Write 0x60: client 1 beats client 3; client 2's ack is ignored.
        expect_ev(EV_WSTB, pack_stb(4'b0010, 8'hA5, 16'h0060));
        expect_ev(EV_STBEND, 32'd4);
        expect_ev(EV_WDONE, 32'd0);
        lpc_addr_i = 16'h0060; lpc_data_i = 8'hA5; lpc_data_wr_i = 1'b1;
        wait_stb("wr60_strobe", 20);
        cl_ack_i = 4'b0100;
        tick(2);
        cl_ack_i = '0;
        tick(1);
        cl_ack_i = 4'b0010;
        tick(1);
        cl_ack_i = '0;
        wr_finish();

        // Reset asserted while read data is being presented.
        expect_ev(EV_RSTB, pack_stb(4'b1000, 8'h00, 16'h002F));
        expect_ev(EV_STBEND, 32'd1);
        expect_ev(EV_RDATA, 32'h177);
        lpc_addr_i = 16'h002F; lpc_rd_req_i = 1'b1;
        wait_stb("rdrst_strobe", 20);
        cl_rdata_i[31:24] = 8'h77; cl_ack_i = 4'b1000;
        tick(1);
        cl_ack_i = '0; cl_rdata_i = '0;
        tick(1);
        #2;
        nrst_i = 1'b0;
        #1;
        chk("rst_mid_flags", {29'd0, lpc_data_rd_o, lpc_data_oe_o, timeout_o}, 32'd0);
        chk("rst_mid_regs", {lpc_data_o, cl_wdata_o, cl_addr_o}, 32'd0);
        lpc_rd_req_i = 1'b0;
        @(negedge clk);
        #2;
        nrst_i = 1'b1;
        tick(2);

        // Write after reset, ack on the first strobe cycle.
        expect_ev(EV_WSTB, pack_stb(4'b0001, 8'h11, 16'h0080));
        expect_ev(EV_STBEND, 32'd1);
        expect_ev(EV_WDONE, 32'd0);
        lpc_addr_i = 16'h0080; lpc_data_i = 8'h11; lpc_data_wr_i = 1'b1;
        tick(2);
        chk("wrpost_strobe", {28'd0, cl_wr_o}, 32'd1);
        cl_ack_i = 4'b0001;
        tick(1);
        cl_ack_i = '0;
        chk("wrpost_done", {27'd0, cl_wr_o, lpc_wr_done_o}, 32'd1);
        wr_finish();

        tick(5);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lpc_io_dispatch.md
# lpc_io_dispatch

Transaction controller between the LPC peripheral's data-provider interface and up to NUM_CLIENTS on-chip I/O register blocks. It decodes each 16-bit I/O address against per-client windows and runs the request/ack handshake with the selected client. It completes the peripheral-side write-done and read-data handshakes. Unclaimed or stalled cycles are terminated by a timeout, so the LPC bus never hangs in long-wait SYNC.

## Interface
- NUM_CLIENTS, 4: number of client ports (1..8).
- BASE, {16'h0080,16'h0060,16'h0064,16'h002E}: flat 16*NUM_CLIENTS vector; client i window base is bits [16i+15:16i].
- MASK, {16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFE}: flat vector; address bit compared only where mask bit is 1.
- TIMEOUT, 255: cycles a client may take before forced completion (1..65535).
- clk_i  in  1  clock; all logic on posedge.
- nrst_i  in  1  reset, asynchronous, active-low.
- lpc_addr_i  in  16  I/O address from peripheral.
- lpc_data_i  in  8  write data from peripheral.
- lpc_data_wr_i  in  1  level; high while the peripheral holds valid write data.
- lpc_wr_done_o  out  1  one-cycle pulse; write consumed.
- lpc_rd_req_i  in  1  level; peripheral requests read data for lpc_addr_i.
- lpc_data_o  out  8  read data toward peripheral.
- lpc_data_oe_o  out  1  top level drives lpc_data_o onto the shared data bus when high.
- lpc_data_rd_o  out  1  level; read data valid.
- lpc_rd_done_i  in  1  peripheral has sampled read data.
- cl_addr_o  out  16  registered address to all clients.
- cl_wdata_o  out  8  registered write data to all clients.
- cl_wr_o  out  NUM_CLIENTS  one-hot write strobe, held until ack.
- cl_rd_o  out  NUM_CLIENTS  one-hot read strobe, held until ack.
- cl_ack_i  in  NUM_CLIENTS  client completion; sampled only on the selected bit.
- cl_rdata_i  in  8*NUM_CLIENTS  flat client read data, valid with ack.
- timeout_o  out  1  one-cycle pulse on forced completion.

## Operation
- States: IDLE, DECODE, WR_ACC, WR_DONE, WR_RELEASE, RD_ACC, RD_VALID, RD_RELEASE.
- IDLE:
  - lpc_data_wr_i=1 → DECODE (write); else lpc_rd_req_i=1 → DECODE (read). Write wins if both are high.
  - Latch addr, data and direction on entry.
- DECODE:
  - Hit on client i when ((addr ^ BASE_i) & MASK_i) == 0. The lowest matching index wins.
  - Hit → WR_ACC or RD_ACC.
  - Miss write → WR_DONE (data dropped).
  - Miss read → RD_VALID with data 8'hFF.
- WR_ACC: cl_wr_o[sel]=1. On cl_ack_i[sel] or timeout → WR_DONE.
- WR_DONE: lpc_wr_done_o=1 for one cycle → WR_RELEASE.
- WR_RELEASE: wait for lpc_data_wr_i=0 → IDLE. This prevents a double-dispatch on a held level.
- RD_ACC: cl_rd_o[sel]=1. On ack, latch cl_rdata_i[sel] → RD_VALID. On timeout, latch 8'hFF → RD_VALID.
- RD_VALID: lpc_data_rd_o=1 and lpc_data_oe_o=1, lpc_data_o stable. On lpc_rd_done_i → RD_RELEASE.
- RD_RELEASE: outputs deasserted; wait for lpc_rd_req_i=0 → IDLE.
- Timeout counter:
  - Cleared on entry to WR_ACC/RD_ACC; increments each cycle in those states.
  - Expires when count == TIMEOUT-1 without ack; timeout_o pulses on that cycle.
  - Ack on the expiry cycle counts as normal completion, with no timeout_o.
- Acks from non-selected clients are ignored.
- Reset (asynchronous, any state):
  - State=IDLE; all strobes, lpc_wr_done_o, lpc_data_rd_o, lpc_data_oe_o and timeout_o = 0.
  - lpc_data_o, cl_addr_o and cl_wdata_o = 0; counter = 0.
  - An in-flight client access is abandoned; clients must tolerate a strobe drop without ack.

## Timing
- All outputs are registered.
- Write hit, ack on first strobe cycle:
  - Request sampled at edge 0; DECODE after edge 0; cl_wr_o high after edge 1.
  - Ack sampled at edge 2; lpc_wr_done_o high after edge 2 for exactly one cycle.
- Write miss: lpc_wr_done_o high after edge 1.
- Read hit, ack on first strobe cycle: lpc_data_rd_o high after edge 2.
- Read miss: lpc_data_rd_o high after edge 1.
- cl_addr_o and cl_wdata_o are stable from DECODE until return to IDLE.
- Strobes are never asserted for more than one client at a time.
- Back-to-back transactions have at least one IDLE cycle between them.

## Structure
- Shared package/defines file (alongside the LPC defines): state encodings, the 8'hFF miss/timeout value, and a default window table.
- Natural sub-module: lpc_io_window_decode. It is combinational: address, BASE and MASK in; hit flag plus index out (priority encoder).
- The FSM, counter and latches stay in lpc_io_dispatch.

## Test plan
- Write 0x80←0x5A, client 0 acks after 3 cycles → cl_wr_o=4'b0001 for 3 cycles, cl_wdata_o=0x5A, single lpc_wr_done_o pulse, no timeout_o.
- Read 0x2F (client 3 via mask), client returns 0xC3 → lpc_data_o=0xC3 with oe, held until lpc_rd_done_i, then release after rd_req drops.
- Write to 0x3F8 (no window) → no client strobe, lpc_wr_done_o one cycle after decode; read 0x3F8 → 0xFF.
- Client 1 never acks on read 0x60 → timeout_o pulse after 255 strobe cycles, lpc_data_o=0xFF, FSM recovers to IDLE.
- Overlapping windows (0x60 matched by clients 1 and 3) → only client 1 strobed; spurious ack from client 2 ignored.
- nrst_i asserted mid RD_VALID → all outputs 0 immediately, next write completes normally.
